// File: rtl/wavegen_cmd_ctrl.sv
// Command queue and decoder between spi_client and the waveform generator core.
// Optional macro WAVEGEN_SYNC_APPLY_EN: waveform changes wait for a phase_wrap pulse while running.
module wavegen_cmd_ctrl #(
    parameter int unsigned        FIFO_DEPTH = 4,
    parameter int unsigned        FREQ_W     = 16,
    parameter logic [FREQ_W-1:0]  FREQ_DEF   = 16'd1024,
    parameter logic [FREQ_W-1:0]  FREQ_STEP  = 16'd256,
    parameter logic [FREQ_W-1:0]  FREQ_MIN   = 16'd256,
    parameter logic [FREQ_W-1:0]  FREQ_MAX   = 16'd16384,
    parameter int unsigned        AMP_W      = 8,
    parameter logic [AMP_W-1:0]   AMP_STEP   = 8'd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        command,
    input  logic              command_signal,
    input  logic              phase_wrap,
    input  logic              cfg_ack,
    output logic [1:0]        wave_sel,
    output logic [FREQ_W-1:0] freq_word,
    output logic [AMP_W-1:0]  amp,
    output logic              run,
    output logic              cfg_valid,
    output logic              busy,
    output logic              cmd_overflow,
    output logic              cmd_error
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_APPLY,
        S_WAIT_ACK
    } state_t;

    state_t r_state, w_state_nxt;

    logic [3:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [3:0]       r_cmd;
    logic             w_full, w_empty, w_push, w_pop;

    logic [1:0]        r_wave, r_sh_wave, w_sh_wave;
    logic [FREQ_W-1:0] r_freq, r_sh_freq, w_sh_freq;
    logic [AMP_W-1:0]  r_amp,  r_sh_amp,  w_sh_amp;
    logic              r_run,  r_sh_run,  w_sh_run;
    logic              r_cfg_valid, r_overflow, r_error;
    logic              w_illegal, w_restore, w_changed, w_load;
    logic [FREQ_W:0]   w_freq_inc;
    logic [AMP_W:0]    w_amp_inc;
    logic              w_apply_ok;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == DEPTH_CNT);
    assign w_pop   = (r_state == S_IDLE) && !w_empty;
    // A pop in the same cycle frees a slot, so a write into a full queue is still accepted.
    assign w_push  = command_signal && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= command;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_cmd    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_cmd    <= r_fifo[r_rd_ptr];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign w_freq_inc = {1'b0, r_sh_freq} + {1'b0, FREQ_STEP};
    assign w_amp_inc  = {1'b0, r_sh_amp} + {1'b0, AMP_STEP};

    always_comb begin
        w_sh_wave = r_sh_wave;
        w_sh_freq = r_sh_freq;
        w_sh_amp  = r_sh_amp;
        w_sh_run  = r_sh_run;
        w_illegal = 1'b0;
        w_restore = 1'b0;
        case (r_cmd)
            4'h0: ;
            4'h1, 4'h2, 4'h3, 4'h4: w_sh_wave = r_cmd[1:0] - 2'd1;
            4'h5: w_sh_freq = (w_freq_inc > {1'b0, FREQ_MAX}) ? FREQ_MAX : w_freq_inc[FREQ_W-1:0];
            4'h6: w_sh_freq = ({1'b0, r_sh_freq} < ({1'b0, FREQ_MIN} + {1'b0, FREQ_STEP}))
                              ? FREQ_MIN : (r_sh_freq - FREQ_STEP);
            4'h7: w_sh_amp  = w_amp_inc[AMP_W] ? '1 : w_amp_inc[AMP_W-1:0];
            4'h8: w_sh_amp  = (r_sh_amp < AMP_STEP) ? '0 : (r_sh_amp - AMP_STEP);
            4'h9: w_sh_run  = 1'b1;
            4'hA: w_sh_run  = 1'b0;
            4'hB: begin
                w_sh_wave = '0;
                w_sh_freq = FREQ_DEF;
                w_sh_amp  = '1;
                w_sh_run  = 1'b0;
                w_restore = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_changed = ({w_sh_wave, w_sh_freq, w_sh_amp, w_sh_run} != {r_wave, r_freq, r_amp, r_run});

`ifdef WAVEGEN_SYNC_APPLY_EN
    logic w_touch;
    assign w_touch    = (r_sh_wave != r_wave) || (r_sh_freq != r_freq) || (r_sh_amp != r_amp);
    assign w_apply_ok = !(r_run && w_touch) || phase_wrap;
`else
    logic w_unused_phase_wrap;
    assign w_unused_phase_wrap = phase_wrap;
    assign w_apply_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE:     if (w_pop) w_state_nxt = S_DECODE;
            S_DECODE:   w_state_nxt = w_changed ? S_APPLY : S_IDLE;
            S_APPLY: begin
                if (w_apply_ok) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: if (cfg_ack) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wave      <= '0;
            r_freq      <= FREQ_DEF;
            r_amp       <= '1;
            r_run       <= 1'b0;
            r_sh_wave   <= '0;
            r_sh_freq   <= FREQ_DEF;
            r_sh_amp    <= '1;
            r_sh_run    <= 1'b0;
            r_cfg_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            if (r_state == S_DECODE) begin
                r_sh_wave <= w_sh_wave;
                r_sh_freq <= w_sh_freq;
                r_sh_amp  <= w_sh_amp;
                r_sh_run  <= w_sh_run;
                if (w_illegal) begin
                    r_error <= 1'b1;
                end
                if (w_restore) begin
                    r_error    <= 1'b0;
                    r_overflow <= 1'b0;
                end
            end
            // A drop in the same cycle as a restore stays flagged: it is the newer event.
            if (command_signal && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_load) begin
                r_wave      <= r_sh_wave;
                r_freq      <= r_sh_freq;
                r_amp       <= r_sh_amp;
                r_run       <= r_sh_run;
                r_cfg_valid <= 1'b1;
            end
            if ((r_state == S_WAIT_ACK) && cfg_ack) begin
                r_cfg_valid <= 1'b0;
            end
        end
    end

    assign wave_sel     = r_wave;
    assign freq_word    = r_freq;
    assign amp          = r_amp;
    assign run          = r_run;
    assign cfg_valid    = r_cfg_valid;
    assign cmd_overflow = r_overflow;
    assign cmd_error    = r_error;
    assign busy         = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_wavegen_cmd_ctrl.sv
// Self-checking bench for wavegen_cmd_ctrl: vector table, scoreboard of applied configurations, corner sequences.
module tb_wavegen_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  command;
    logic        command_signal, phase_wrap, cfg_ack;
    logic [1:0]  wave_sel;
    logic [15:0] freq_word;
    logic [7:0]  amp;
    logic        run, cfg_valid, busy, cmd_overflow, cmd_error;

    always #5 clk = ~clk;

    wavegen_cmd_ctrl #(
        .FIFO_DEPTH (4),
        .FREQ_W     (16),
        .FREQ_DEF   (16'd1024),
        .FREQ_STEP  (16'd256),
        .FREQ_MIN   (16'd256),
        .FREQ_MAX   (16'd16384),
        .AMP_W      (8),
        .AMP_STEP   (8'd16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .command        (command),
        .command_signal (command_signal),
        .phase_wrap     (phase_wrap),
        .cfg_ack        (cfg_ack),
        .wave_sel       (wave_sel),
        .freq_word      (freq_word),
        .amp            (amp),
        .run            (run),
        .cfg_valid      (cfg_valid),
        .busy           (busy),
        .cmd_overflow   (cmd_overflow),
        .cmd_error      (cmd_error)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  wave;
        logic [15:0] freq;
        logic [7:0]  amp;
        logic        run;
        logic        v;
        logic        err;
    } vec_t;

    vec_t        tbl [12];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [26:0] sb_q [$];
    logic        prev_valid = 1'b0;
    logic [1:0]  m_wave;
    logic [15:0] m_freq;
    logic [7:0]  m_amp;
    logic        m_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Each new cfg_valid pulse must present the oldest outstanding expected configuration.
    always @(negedge clk) begin
        logic [26:0] e;
        if (cfg_valid === 1'b1 && !prev_valid) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_unexpected_valid: got cfg_valid=1 expected no pending config at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                check("sb_cfg", {5'b0, wave_sel, freq_word, amp, run}, {5'b0, e});
            end
        end
        prev_valid = cfg_valid;
    end

    task automatic push_model();
        sb_q.push_back({m_wave, m_freq, m_amp, m_run});
    endtask

    task automatic send(input logic [3:0] c);
        command        = c;
        command_signal = 1'b1;
        @(negedge clk);
        command_signal = 1'b0;
        command        = '0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got busy=1 expected busy=0 within 60 cycles", name);
        end
    endtask

    task automatic model_freq(input bit up);
        logic [16:0] t;
        logic [15:0] old;
        old = m_freq;
        if (up) begin
            t      = {1'b0, m_freq} + 17'd256;
            m_freq = (t > 17'd16384) ? 16'd16384 : t[15:0];
        end else begin
            m_freq = (m_freq < 16'd512) ? 16'd256 : m_freq - 16'd256;
        end
        if (m_freq != old) push_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wave"}, wave_sel, 0);
        check({tag, "_freq"}, freq_word, 1024);
        check({tag, "_amp"},  amp, 255);
        check({tag, "_run"},  run, 0);
        check({tag, "_valid"}, cfg_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ovf"},  cmd_overflow, 0);
        check({tag, "_err"},  cmd_error, 0);
    endtask

    initial begin
        int n;
        logic [3:0] burst [6];

        tbl[0]  = '{4'h1, 2'd0, 16'd1024, 8'd255, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{4'h4, 2'd3, 16'd1024, 8'd255, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{4'h4, 2'd3, 16'd1024, 8'd255, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{4'h7, 2'd3, 16'd1024, 8'd255, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{4'h8, 2'd3, 16'd1024, 8'd239, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{4'h7, 2'd3, 16'd1024, 8'd255, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{4'h0, 2'd3, 16'd1024, 8'd255, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{4'hE, 2'd3, 16'd1024, 8'd255, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{4'h6, 2'd3, 16'd768,  8'd255, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{4'h9, 2'd3, 16'd768,  8'd255, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{4'hA, 2'd3, 16'd768,  8'd255, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{4'hB, 2'd0, 16'd1024, 8'd255, 1'b0, 1'b1, 1'b0};

        rst = 1'b0; command = '0; command_signal = 1'b0; phase_wrap = 1'b0; cfg_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Latency: strobe in cycle 0, configuration visible in cycle 4.
        m_wave = 2'd1; m_freq = 16'd1024; m_amp = 8'd255; m_run = 1'b0;
        push_model();
        send(4'h2);
        repeat (2) @(negedge clk);
        check("lat_c3_valid", cfg_valid, 0);
        @(negedge clk);
        check("lat_c4_valid", cfg_valid, 1);
        check("lat_c4_wave", wave_sel, 1);
        cfg_ack = 1'b1;
        @(negedge clk);
        check("lat_ack_valid", cfg_valid, 0);
        check("lat_ack_busy", busy, 0);

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].v) sb_q.push_back({tbl[i].wave, tbl[i].freq, tbl[i].amp, tbl[i].run});
            send(tbl[i].cmd);
            wait_idle("tbl");
            check($sformatf("tbl%0d_wave", i), wave_sel, tbl[i].wave);
            check($sformatf("tbl%0d_freq", i), freq_word, tbl[i].freq);
            check($sformatf("tbl%0d_amp", i), amp, tbl[i].amp);
            check($sformatf("tbl%0d_run", i), run, tbl[i].run);
            check($sformatf("tbl%0d_err", i), cmd_error, tbl[i].err);
        end
        m_wave = 2'd0; m_freq = 16'd1024; m_amp = 8'd255; m_run = 1'b0;

        for (int i = 0; i < 70; i++) begin
            model_freq(1'b1);
            send(4'h5);
            wait_idle("fup");
            check("fup_freq", freq_word, m_freq);
        end
        check("fup_sat", freq_word, 16384);
        for (int i = 0; i < 70; i++) begin
            model_freq(1'b0);
            send(4'h6);
            wait_idle("fdn");
            check("fdn_freq", freq_word, m_freq);
        end
        check("fdn_sat", freq_word, 256);

        // Six back-to-back strobes with no ack: one in service, four queued, the sixth dropped.
        cfg_ack = 1'b0;
        burst[0] = 4'h2; burst[1] = 4'h3; burst[2] = 4'h4;
        burst[3] = 4'h1; burst[4] = 4'h2; burst[5] = 4'h3;
        for (int i = 0; i < 5; i++) begin
            m_wave = burst[i][1:0] - 2'd1;
            push_model();
        end
        for (int i = 0; i < 6; i++) begin
            command = burst[i];
            command_signal = 1'b1;
            @(negedge clk);
        end
        command_signal = 1'b0;
        repeat (2) @(negedge clk);
        check("ovf_flag", cmd_overflow, 1);
        check("ovf_busy", busy, 1);
        check("ovf_valid", cfg_valid, 1);
        check("ovf_wave_hold", wave_sel, 1);
        cfg_ack = 1'b1;
        wait_idle("ovf_drain");
        check("ovf_drain_wave", wave_sel, 1);
        check("ovf_flag_kept", cmd_overflow, 1);
        m_wave = 2'd0; m_freq = 16'd1024; m_amp = 8'd255; m_run = 1'b0;
        push_model();
        send(4'hB);
        wait_idle("restore");
        check("restore_ovf", cmd_overflow, 0);
        check("restore_freq", freq_word, 1024);
        check("restore_wave", wave_sel, 0);

        m_run = 1'b1;
        push_model();
        send(4'h9);
        wait_idle("run_on");
        check("run_on", run, 1);
        m_wave = 2'd2;
        push_model();
`ifdef WAVEGEN_SYNC_APPLY_EN
        send(4'h3);
        repeat (19) @(negedge clk);
        check("sync_wait_wave", wave_sel, 0);
        check("sync_wait_busy", busy, 1);
        check("sync_wait_valid", cfg_valid, 0);
        phase_wrap = 1'b1;
        @(negedge clk);
        phase_wrap = 1'b0;
        check("sync_load_wave", wave_sel, 2);
        check("sync_load_valid", cfg_valid, 1);
`else
        send(4'h3);
        repeat (3) @(negedge clk);
        check("nosync_wave", wave_sel, 2);
        check("nosync_valid", cfg_valid, 1);
`endif
        wait_idle("wave3");
        m_run = 1'b0;
        push_model();
        send(4'hA);
        repeat (3) @(negedge clk);
        check("stop_valid", cfg_valid, 1);
        check("stop_run", run, 0);
        wait_idle("stop");
        check("sb_drained", sb_q.size(), 0);

        // Reset while waiting for ack with two commands still queued.
        cfg_ack = 1'b0;
        m_wave = 2'd3;
        push_model();
        send(4'h4);
        send(4'h1);
        send(4'h2);
        n = 0;
        while (cfg_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached_wait", cfg_valid, 1);
        @(negedge clk);
        check("rst_mid_busy", busy, 1);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        sb_q.delete();
        @(negedge clk);
        rst = 1'b1;
        cfg_ack = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", cfg_valid, 0);
        check("post_rst_wave", wave_sel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
